freq_counter_mc: RTL and testbench
==================================

# freq_counter_mc

Multi-channel reciprocal frequency counter with a Wishbone slave register interface. It replaces the single-channel, multi-clock counter with a fully synchronous design. Up to 8 asynchronous input signals are synchronised into `clk_i`. For each channel, the block counts `clk_i` cycles across a programmable number of input periods (the gate). Software reads the per-channel cycle totals and computes f_in = GATE × f_clk / COUNT.

## Interface
- `CHANNELS`, 4: number of measured inputs, 1..8.
- `COUNT_W`, 32: width of each result counter, 16..32.
- `GATE_W`, 16: width of the gate (input-period count) register.
- `SYNC_STAGES`, 2: synchroniser flops per input, ≥2.
- `clk_i`  in  1  sole clock, also the reference timebase.
- `ext_rst_i`  in  1  synchronous active-low reset.
- `addr_i`  in  32  word address.
- `dat_i`  in  32  write data.
- `we_i`  in  1  write enable.
- `sel_i`  in  4  byte selects; ignored, full-word access only.
- `cyc_i`  in  1  bus cycle.
- `stb_i`  in  1  strobe.
- `signal_i`  in  CHANNELS  asynchronous inputs to measure.
- `dat_o`  out  32  read data.
- `ack_o`  out  1  access acknowledge.
- `err_o`  out  1  access error.
- `busy_o`  out  CHANNELS  per-channel measurement in progress.
- `irq_o`  out  1  OR of all DONE bits.

## Operation
- Register map (word addresses); unimplemented bits read 0:
  - 0x0 CTRL [CHANNELS-1:0]: writing 1 starts that channel; writing 0 aborts it. Reads return `busy_o`.
  - 0x1 STATUS: [7:0] DONE, [15:8] OVF, [23:16] TMO. All bits are write-1-to-clear.
  - 0x2 GATE [GATE_W-1:0]. Reset value 1. A value of 0 behaves as 1.
  - 0x3 TIMEOUT [31:0]: only present when the timeout macro is defined.
  - 0x4+ch COUNT[ch]: read-only result.
- Per-channel input path: `SYNC_STAGES` flops, then one edge-detect flop. A rising edge pulses for one cycle.
- Per-channel FSM:
  - IDLE: on a start write, clear `cnt`, `edges`, and the channel's DONE/OVF/TMO bits, then go to ARM. A start write while not IDLE is ignored.
  - ARM: on a rising edge, set `cnt`=0 and `edges`=0, then go to MEAS.
  - MEAS: `cnt` increments every cycle and saturates at all-ones, setting OVF. Each edge increments `edges`. On the edge where `edges`+1 == GATE, latch COUNT = `cnt`+1 (saturating), set DONE, and go to IDLE.
  - Abort: a CTRL write of 0 for a busy channel returns it to IDLE immediately. COUNT and DONE are left unchanged.
- GATE is sampled on the ARM→MEAS transition. Writing GATE mid-measurement does not affect the running channel.
- Bus access: `ack_o` or `err_o` is asserted one cycle after `cyc_i & stb_i`, for exactly one cycle. There is no new access while either is high.
  - `err_o` is raised for an unmapped address or a write to COUNT. The register state is then unchanged and `dat_o`=0.
- Simultaneous events:
  - Hardware set of DONE/OVF/TMO and a W1C in the same cycle: the set wins.
  - Start write and abort of the same channel in one write: not possible, since one bit carries both.
- Reset (`ext_rst_i`=0 at a `clk_i` edge): all FSMs go to IDLE, COUNT=0, STATUS=0, GATE=1, TIMEOUT=0.
  - Outputs: `dat_o`=0, `ack_o`=0, `err_o`=0, `busy_o`=0, `irq_o`=0.
  - Synchroniser flops clear to 0. Reset mid-measurement discards the measurement.

## Timing
- Input edge to detect pulse: SYNC_STAGES+1 cycles. Both gate edges see the same delay, so COUNT is exact: a period of P cycles gives COUNT = GATE × P.
- Start write acked at cycle N gives `busy_o` high at cycle N.
- The final edge pulse at cycle M gives COUNT and DONE valid, and `busy_o` low, at cycle M+1. `irq_o` is high at M+1.
- Minimum measurable input period: 2 `clk_i` cycles (high and low each ≥1 cycle).

## Configuration
- `FC_TIMEOUT_EN` defined:
  - TIMEOUT register present at 0x3. A value of 0 disables the watchdog.
  - In ARM or MEAS, a per-channel watchdog counts cycles since the last detected edge (or since the start).
  - When it reaches TIMEOUT, the channel sets TMO and DONE, sets COUNT=0, and goes to IDLE.
- `FC_TIMEOUT_EN` undefined:
  - No watchdog logic; address 0x3 returns `err_o`.
  - TMO bits read 0.
  - A channel with no input stays in ARM until aborted.

## Test plan
- Reset: hold `ext_rst_i`=0 for 3 cycles → all outputs 0, GATE reads 1, STATUS reads 0.
- Single channel: ch0 period 10 cycles, GATE=4, start ch0 → DONE[0]=1, COUNT0=40, `irq_o`=1. W1C DONE[0] → `irq_o`=0.
- Concurrency: ch0 period 7, ch3 period 13, GATE=100, both started in one write → COUNT0=700, COUNT3=1300, other channels stay IDLE.
- Overflow: with COUNT_W=16, period 1000, GATE=100 → OVF=1, COUNT=0xFFFF.
- Abort and bus errors:
  - Abort ch1 mid-MEAS → `busy_o[1]`=0, COUNT1 unchanged.
  - Read 0x20 → `err_o`=1, `dat_o`=0.
  - Write COUNT0 → `err_o`=1.
- Timeout (`FC_TIMEOUT_EN`): TIMEOUT=50, ch2 held low, start → TMO[2]=1 and DONE[2]=1 at 50 cycles after start, COUNT2=0.

Source files
------------

// File: rtl/freq_counter_mc.sv
// Multi-channel reciprocal frequency counter with a Wishbone register interface.
// Define FC_TIMEOUT_EN to add the TIMEOUT register (0x3) and per-channel watchdogs.

module freq_counter_mc_chan #(
  parameter int COUNT_W     = 32,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sig_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [GATE_W-1:0]  gate_i,
  input  logic               clr_done_i,
  input  logic               clr_ovf_i,
`ifdef FC_TIMEOUT_EN
  input  logic [31:0]        tmo_lim_i,
  input  logic               clr_tmo_i,
  output logic               tmo_o,
`endif
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o,
  output logic [COUNT_W-1:0] count_o
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_e;

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [GATE_W-1:0]  GATE_ONE = GATE_W'(1);

  state_e                 st_q, st_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, rise;
  logic [COUNT_W-1:0]     cnt_q, cnt_d, count_q, count_d;
  logic [GATE_W-1:0]      edges_q, edges_d, glim_q, glim_d;
  logic                   done_q, done_d, ovf_q, ovf_d;
`ifdef FC_TIMEOUT_EN
  logic [31:0]            wd_q, wd_d, wd_inc;
  logic                   tmo_q, tmo_d;
  assign wd_inc = wd_q + 32'd1;
`endif

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    edges_d = edges_q;
    glim_d  = glim_q;
    count_d = count_q;
    done_d  = done_q & ~clr_done_i;
    ovf_d   = ovf_q & ~clr_ovf_i;
    unique case (st_q)
      IDLE: if (start_i) begin
        st_d    = ARM;
        cnt_d   = '0;
        edges_d = '0;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
      end
      ARM: if (abort_i) st_d = IDLE;
        else if (rise) begin
          st_d    = MEAS;
          cnt_d   = '0;
          edges_d = '0;
          glim_d  = (gate_i == '0) ? GATE_ONE : gate_i;
        end
      MEAS: if (abort_i) st_d = IDLE;
        else begin
          // cnt holds cycles since the opening edge minus one; the closing edge adds it back
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else cnt_d = cnt_q + CNT_ONE;
          if (rise) begin
            if (edges_q + GATE_ONE == glim_q) begin
              st_d    = IDLE;
              done_d  = 1'b1;
              count_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            end else edges_d = edges_q + GATE_ONE;
          end
        end
      default: st_d = IDLE;
    endcase
`ifdef FC_TIMEOUT_EN
    wd_d  = wd_q;
    tmo_d = tmo_q & ~clr_tmo_i;
    if (st_q == IDLE) begin
      wd_d = '0;
      if (start_i) tmo_d = 1'b0;
    end else if (!abort_i) begin
      if (rise) wd_d = '0;
      else begin
        wd_d = wd_inc;
        if (tmo_lim_i != '0 && wd_inc == tmo_lim_i) begin
          st_d    = IDLE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
          count_d = '0;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q    <= IDLE;
      sync_q  <= '0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      edges_q <= '0;
      glim_q  <= GATE_ONE;
      count_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef FC_TIMEOUT_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      st_q    <= st_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      glim_q  <= glim_d;
      count_q <= count_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef FC_TIMEOUT_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign busy_o  = (st_q != IDLE);
  assign done_o  = done_q;
  assign ovf_o   = ovf_q;
  assign count_o = count_q;
`ifdef FC_TIMEOUT_EN
  assign tmo_o   = tmo_q;
`endif
endmodule

module freq_counter_mc #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_W     = 32,
  parameter int GATE_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                ext_rst_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         dat_i,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic [CHANNELS-1:0] signal_i,
  output logic [31:0]         dat_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [CHANNELS-1:0] busy_o,
  output logic                irq_o
);
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
  } wb_req_t;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } wb_rsp_t;

`ifdef FC_TIMEOUT_EN
  localparam bit HAS_TMO = 1'b1;
  logic [31:0] timeout_q, timeout_d;
`else
  localparam bit HAS_TMO = 1'b0;
`endif

  wb_req_t                          req;
  wb_rsp_t                          rsp_q, rsp_d;
  logic                             acc, is_cnt, bad, wr, wr_ctrl, wr_stat;
  logic [31:0]                      rdata;
  logic [GATE_W-1:0]                gate_q, gate_d;
  logic [CHANNELS-1:0]              busy_v, done_v, ovf_v, tmo_v;
  logic [CHANNELS-1:0][COUNT_W-1:0] count_v;
  logic                             unused_bits;

  assign unused_bits = ^{sel_i, dat_i};
  assign req = '{we: we_i, addr: addr_i, wdat: dat_i};
  // ack/err high blocks a new access, so every response is exactly one cycle
  assign acc = cyc_i & stb_i & ~rsp_q.ack & ~rsp_q.err;

  always_comb begin
    is_cnt = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      if (req.addr == 32'(4 + c)) is_cnt = 1'b1;
    bad = !(is_cnt || req.addr < 32'd3 || (HAS_TMO && req.addr == 32'd3)) ||
          (req.we && is_cnt);
    rdata = '0;
    case (req.addr)
      32'd0: rdata = 32'(busy_v);
      32'd1: rdata = {8'h00, 8'(tmo_v), 8'(ovf_v), 8'(done_v)};
      32'd2: rdata = 32'(gate_q);
`ifdef FC_TIMEOUT_EN
      32'd3: rdata = timeout_q;
`endif
      default:
        for (int c = 0; c < CHANNELS; c++)
          if (req.addr == 32'(4 + c)) rdata = 32'(count_v[c]);
    endcase
  end

  assign wr      = acc & req.we & ~bad;
  assign wr_ctrl = wr & (req.addr == 32'd0);
  assign wr_stat = wr & (req.addr == 32'd1);

  always_comb begin
    rsp_d.ack = acc & ~bad;
    rsp_d.err = acc & bad;
    rsp_d.dat = (acc & ~req.we & ~bad) ? rdata : '0;
    gate_d    = (wr && req.addr == 32'd2) ? req.wdat[GATE_W-1:0] : gate_q;
`ifdef FC_TIMEOUT_EN
    timeout_d = (wr && req.addr == 32'd3) ? req.wdat : timeout_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!ext_rst_i) begin
      rsp_q     <= '0;
      gate_q    <= GATE_W'(1);
`ifdef FC_TIMEOUT_EN
      timeout_q <= '0;
`endif
    end else begin
      rsp_q     <= rsp_d;
      gate_q    <= gate_d;
`ifdef FC_TIMEOUT_EN
      timeout_q <= timeout_d;
`endif
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    freq_counter_mc_chan #(
      .COUNT_W(COUNT_W), .GATE_W(GATE_W), .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_ni     (ext_rst_i),
      .sig_i      (signal_i[c]),
      .start_i    (wr_ctrl & req.wdat[c]),
      .abort_i    (wr_ctrl & ~req.wdat[c]),
      .gate_i     (gate_q),
      .clr_done_i (wr_stat & req.wdat[c]),
      .clr_ovf_i  (wr_stat & req.wdat[8+c]),
`ifdef FC_TIMEOUT_EN
      .tmo_lim_i  (timeout_q),
      .clr_tmo_i  (wr_stat & req.wdat[16+c]),
      .tmo_o      (tmo_v[c]),
`endif
      .busy_o     (busy_v[c]),
      .done_o     (done_v[c]),
      .ovf_o      (ovf_v[c]),
      .count_o    (count_v[c])
    );
  end

`ifndef FC_TIMEOUT_EN
  assign tmo_v = '0;
`endif

  assign dat_o  = rsp_q.dat;
  assign ack_o  = rsp_q.ack;
  assign err_o  = rsp_q.err;
  assign busy_o = busy_v;
  assign irq_o  = |done_v;
endmodule

// File: tb/tb_freq_counter_mc.sv
// Randomised bench for freq_counter_mc: square-wave sources against an
// arithmetic model (COUNT = min(GATE*P, max), OVF when the product overflows).

module tb_freq_counter_mc;
  localparam int CH   = 4;
  localparam int CW   = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [31:0]   addr = '0, wdat = '0, dat_o;
  logic          we = 1'b0, cyc = 1'b0, stb = 1'b0, ack, err, irq;
  logic [3:0]    sel = 4'hF;
  logic [CH-1:0] sig = '0, busy;

  int per[CH] = '{default: 0};
  int cur[CH] = '{default: 0};
  int ph[CH]  = '{default: 0};
  int n_cmp = 0, n_bad = 0;

  int ex_count[CH] = '{default: 0};
  int ex_gate[CH]  = '{default: 1};
  bit ex_done[CH]  = '{default: 0};
  bit ex_ovf[CH]   = '{default: 0};
  bit ex_tmo[CH]   = '{default: 0};

  freq_counter_mc #(.CHANNELS(CH), .COUNT_W(CW), .GATE_W(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .ext_rst_i(rst_n), .addr_i(addr), .dat_i(wdat), .we_i(we),
    .sel_i(sel), .cyc_i(cyc), .stb_i(stb), .signal_i(sig), .dat_o(dat_o),
    .ack_o(ack), .err_o(err), .busy_o(busy), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Period P: high for P/2 cycles, low for the rest; a period change restarts the wave high.
  always @(negedge clk)
    for (int c = 0; c < CH; c++) begin
      if (per[c] != cur[c]) begin
        cur[c] = per[c];
        ph[c]  = 0;
      end else if (cur[c] >= 2) ph[c] = (ph[c] + 1 >= cur[c]) ? 0 : ph[c] + 1;
      sig[c] = (cur[c] >= 2) && (ph[c] < cur[c] / 2);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input bit exp_err, output logic [31:0] rd);
    @(negedge clk);
    if (ack || err) @(negedge clk);
    we = w; addr = a; wdat = d; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("resp@%0h", a), {30'd0, err, ack}, exp_err ? 32'd2 : 32'd1);
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] x;
    wb(1'b1, a, d, 1'b0, x);
  endtask

  task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] x;
    wb(1'b0, a, 32'd0, 1'b0, x);
    chk(tag, x, exp);
  endtask

  task automatic start(input logic [CH-1:0] m, input int g);
    wr(32'd2, 32'(g));
    wr(32'd0, 32'(m));
    chk("busy_at_start_ack", 32'(busy), 32'(m));
    for (int c = 0; c < CH; c++)
      if (m[c]) begin
        ex_done[c] = 0; ex_ovf[c] = 0; ex_tmo[c] = 0;
        ex_gate[c] = (g == 0) ? 1 : g;
      end
  endtask

  task automatic wait_done(input logic [CH-1:0] m, input int budget);
    int n = 0;
    while ((busy & m) != '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("meas_in_budget", 32'((busy & m) == '0), 32'd1);
    chk("irq_with_done", 32'(irq), 32'd1);
    for (int c = 0; c < CH; c++)
      if (m[c]) begin
        longint total = longint'(ex_gate[c]) * per[c];
        ex_count[c] = (total > CMAX) ? CMAX : int'(total);
        ex_ovf[c]   = (total > CMAX);
        ex_done[c]  = 1;
      end
  endtask

  task automatic w1c(input logic [31:0] w);
    wr(32'd1, w);
    for (int c = 0; c < CH; c++) begin
      if (w[c])    ex_done[c] = 0;
      if (w[8+c])  ex_ovf[c]  = 0;
      if (w[16+c]) ex_tmo[c]  = 0;
    end
  endtask

  task automatic verify(input string tag);
    logic [31:0] s = '0;
    bit any = 0;
    for (int c = 0; c < CH; c++) begin
      s[c] = ex_done[c]; s[8+c] = ex_ovf[c]; s[16+c] = ex_tmo[c];
      any |= ex_done[c];
    end
    rdchk({tag, "_status"}, 32'd1, s);
    for (int c = 0; c < CH; c++)
      rdchk($sformatf("%s_count%0d", tag, c), 32'(4 + c), 32'(ex_count[c]));
    chk({tag, "_irq"}, 32'(irq), 32'(any));
  endtask

  initial begin
    logic [31:0] x;
    logic [CH-1:0] m;
    int g;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_ack_err", {30'd0, ack, err}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    rdchk("rst_gate", 32'd2, 32'd1);
    rdchk("rst_status", 32'd1, 32'd0);
    rdchk("rst_ctrl", 32'd0, 32'd0);
    rdchk("rst_count0", 32'd4, 32'd0);

    // single channel
    per[0] = 10;
    start(4'b0001, 4);
    wait_done(4'b0001, 300);
    rdchk("single_count0", 32'd4, 32'd40);
    verify("single");
    w1c(32'h1);
    chk("irq_after_w1c", 32'(irq), 32'd0);

    // bus errors
    wb(1'b0, 32'h20, 32'd0, 1'b1, x);
    chk("unmapped_dat", x, 32'd0);
    wb(1'b1, 32'd4, 32'hDEAD, 1'b1, x);
    rdchk("count0_after_bad_wr", 32'd4, 32'd40);
`ifndef FC_TIMEOUT_EN
    wb(1'b0, 32'd3, 32'd0, 1'b1, x);
    chk("tmo_reg_absent_dat", x, 32'd0);
`endif

    // concurrency
    per[0] = 7; per[3] = 13;
    start(4'b1001, 100);
    wait_done(4'b1001, 3000);
    rdchk("conc_count0", 32'd4, 32'd700);
    rdchk("conc_count3", 32'd7, 32'd1300);
    verify("conc");

    // abort mid-measurement
    per[1] = 20;
    start(4'b0010, 10);
    repeat (60) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'h2);
    wr(32'd0, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    verify("abort");

    // overflow with 16-bit counters
    per[2] = 656;
    start(4'b0100, 100);
    wait_done(4'b0100, 70000);
    rdchk("ovf_count2", 32'd6, 32'hFFFF);
    verify("ovf");

    // randomised runs
    for (int it = 0; it < 8; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < CH; c++) if (m[c]) per[c] = $urandom_range(2, 30);
      g = $urandom_range(0, 12);
      start(m, g);
      wait_done(m, 2000);
      w1c($urandom & 32'h000F0F0F);
      verify($sformatf("rnd%0d", it));
    end

`ifdef FC_TIMEOUT_EN
    begin
      int n = 0;
      wr(32'd3, 32'd50);
      per[2] = 0;
      repeat (6) @(negedge clk);
      start(4'b0100, 1);
      while (busy[2] && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      chk("tmo_cycles", 32'(n), 32'd50);
      ex_done[2] = 1; ex_tmo[2] = 1; ex_count[2] = 0;
      verify("tmo");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
